// File: rtl/noc_merge_arbiter.sv
// rtl/noc_merge_arbiter.sv - two-requester round-robin merge into one registered output stage
module noc_merge_arbiter #(
  parameter int W  = 11,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [W-1:0]  in0_data,
  input  logic          in0_route,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [W-1:0]  in1_data,
  input  logic          in1_route,
  input  logic          in1_valid,
  output logic          in1_ready,
  output logic [W-1:0]  out_data,
  output logic          out_route,
  output logic          out_src,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] gnt_cnt0,
  output logic [CW-1:0] gnt_cnt1
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_prio;
  logic [W-1:0]  r_data;
  logic          r_route;
  logic          r_src;
  logic [CW-1:0] r_cnt0;
  logic [CW-1:0] r_cnt1;

  logic          w_load_en;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_accept;
  logic          w_cnt0_max;
  logic          w_cnt1_max;

  // Grant decode: the output register may load when empty or draining; reset blocks all grants.
  always_comb begin
    w_load_en  = !RESET && ((r_state == ST_EMPTY) || out_ready);
    w_gnt0     = w_load_en && in0_valid && (!in1_valid || !r_prio);
    w_gnt1     = w_load_en && in1_valid && (!in0_valid ||  r_prio);
    w_accept   = w_gnt0 || w_gnt1;
    w_cnt0_max = (r_cnt0 == {CW{1'b1}});
    w_cnt1_max = (r_cnt1 == {CW{1'b1}});
  end

  assign in0_ready = w_gnt0;
  assign in1_ready = w_gnt1;

  // Output FSM, packet register, round-robin pointer and saturating grant counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_EMPTY;
      r_prio  <= 1'b0;
      r_data  <= '0;
      r_route <= 1'b0;
      r_src   <= 1'b0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) r_state <= ST_FULL;
        end
        ST_FULL: begin
          // A new accept while draining keeps the stage full with no bubble.
          if (out_ready && !w_accept) r_state <= ST_EMPTY;
        end
        default: r_state <= ST_EMPTY;
      endcase

      if (w_gnt0) begin
        r_data  <= in0_data;
        r_route <= in0_route;
        r_src   <= 1'b0;
        r_prio  <= 1'b1;
      end else if (w_gnt1) begin
        r_data  <= in1_data;
        r_route <= in1_route;
        r_src   <= 1'b1;
        r_prio  <= 1'b0;
      end

      if (w_gnt0 && !w_cnt0_max) r_cnt0 <= r_cnt0 + CW'(1);
      if (w_gnt1 && !w_cnt1_max) r_cnt1 <= r_cnt1 + CW'(1);
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_route = r_route;
  assign out_src   = r_src;
  assign gnt_cnt0  = r_cnt0;
  assign gnt_cnt1  = r_cnt1;

endmodule

// File: tb/tb_noc_merge_arbiter.sv
// tb/tb_noc_merge_arbiter.sv - self-checking bench for noc_merge_arbiter
module tb_noc_merge_arbiter;

  logic        CLK;
  logic        RESET;
  logic [10:0] in0_data, in1_data;
  logic        in0_route, in1_route;
  logic        in0_valid, in1_valid;
  logic        in0_ready, in1_ready;
  logic [10:0] out_data;
  logic        out_route, out_src, out_valid, out_ready;
  logic [7:0]  gnt_cnt0, gnt_cnt1;

  logic        s_in0_ready, s_in1_ready;
  logic [10:0] s_out_data;
  logic        s_out_route, s_out_src, s_out_valid;
  logic [1:0]  s_gnt_cnt0, s_gnt_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  noc_merge_arbiter #(.W(11), .CW(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .in0_data(in0_data), .in0_route(in0_route), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_route(in1_route), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_route(out_route), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  noc_merge_arbiter #(.W(11), .CW(2)) dut_small (
    .CLK(CLK), .RESET(RESET),
    .in0_data(in0_data), .in0_route(in0_route), .in0_valid(in0_valid), .in0_ready(s_in0_ready),
    .in1_data(in1_data), .in1_route(in1_route), .in1_valid(in1_valid), .in1_ready(s_in1_ready),
    .out_data(s_out_data), .out_route(s_out_route), .out_src(s_out_src), .out_valid(s_out_valid),
    .out_ready(out_ready), .gnt_cnt0(s_gnt_cnt0), .gnt_cnt1(s_gnt_cnt1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic v0, input logic [10:0] d0, input logic r0,
                        input logic v1, input logic [10:0] d1, input logic r1,
                        input logic ordy);
    in0_valid = v0; in0_data = d0; in0_route = r0;
    in1_valid = v1; in1_data = d1; in1_route = r1;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    set_in(1'b0, 11'h0, 1'b0, 1'b0, 11'h0, 1'b0, 1'b0);
    tick();
    RESET = 1'b0;
  endtask

  typedef struct {
    logic        v0; logic [10:0] d0; logic r0;
    logic        v1; logic [10:0] d1; logic r1;
    logic        ordy;
    logic        e_rdy0; logic e_rdy1; logic e_ov;
    logic        chk_pkt; logic [10:0] e_data; logic e_route; logic e_src;
    logic [7:0]  e_c0; logic [7:0] e_c1;
  } vec_t;

  typedef struct {
    logic [10:0] data;
    logic        route;
    logic        src;
  } pkt_t;

  vec_t vt[6];
  pkt_t q[$];
  logic [10:0] held_data;
  logic        held_route, held_src;

  initial begin
    // Vectors applied back-to-back from reset (prio starts at 0, stage empty).
    vt[0] = '{1'b1, 11'h005, 1'b1, 1'b0, 11'h000, 1'b0, 1'b1,
              1'b1, 1'b0, 1'b1, 1'b1, 11'h005, 1'b1, 1'b0, 8'd1, 8'd0};
    vt[1] = '{1'b1, 11'h0AA, 1'b0, 1'b1, 11'h155, 1'b1, 1'b1,
              1'b0, 1'b1, 1'b1, 1'b1, 11'h155, 1'b1, 1'b1, 8'd1, 8'd1};
    vt[2] = '{1'b1, 11'h0AA, 1'b0, 1'b1, 11'h155, 1'b1, 1'b1,
              1'b1, 1'b0, 1'b1, 1'b1, 11'h0AA, 1'b0, 1'b0, 8'd2, 8'd1};
    vt[3] = '{1'b1, 11'h011, 1'b1, 1'b1, 11'h022, 1'b1, 1'b0,
              1'b0, 1'b0, 1'b1, 1'b1, 11'h0AA, 1'b0, 1'b0, 8'd2, 8'd1};
    vt[4] = '{1'b0, 11'h011, 1'b1, 1'b0, 11'h022, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 8'd2, 8'd1};
    vt[5] = '{1'b0, 11'h000, 1'b0, 1'b1, 11'h7FF, 1'b0, 1'b0,
              1'b0, 1'b1, 1'b1, 1'b1, 11'h7FF, 1'b0, 1'b1, 8'd2, 8'd2};

    // Reset state, readys held low during reset even with valids present.
    RESET = 1'b1;
    set_in(1'b1, 11'h123, 1'b1, 1'b1, 11'h456, 1'b1, 1'b1);
    #1;
    chk("rst_rdy0", in0_ready, 0);
    chk("rst_rdy1", in1_ready, 0);
    tick();
    chk("rst_ov", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_route", out_route, 0);
    chk("rst_src", out_src, 0);
    chk("rst_c0", gnt_cnt0, 0);
    chk("rst_c1", gnt_cnt1, 0);
    RESET = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      set_in(vt[i].v0, vt[i].d0, vt[i].r0, vt[i].v1, vt[i].d1, vt[i].r1, vt[i].ordy);
      #1;
      chk($sformatf("vec%0d_rdy0", i), in0_ready, vt[i].e_rdy0);
      chk($sformatf("vec%0d_rdy1", i), in1_ready, vt[i].e_rdy1);
      tick();
      chk($sformatf("vec%0d_ov", i), out_valid, vt[i].e_ov);
      if (vt[i].chk_pkt) begin
        chk($sformatf("vec%0d_data", i), out_data, vt[i].e_data);
        chk($sformatf("vec%0d_route", i), out_route, vt[i].e_route);
        chk($sformatf("vec%0d_src", i), out_src, vt[i].e_src);
      end
      chk($sformatf("vec%0d_c0", i), gnt_cnt0, vt[i].e_c0);
      chk($sformatf("vec%0d_c1", i), gnt_cnt1, vt[i].e_c1);
    end

    // Both valid continuously: grants alternate with no bubbles.
    do_reset();
    set_in(1'b1, 11'h100, 1'b0, 1'b1, 11'h200, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("alt%0d_ov", i), out_valid, 1);
      chk($sformatf("alt%0d_src", i), out_src, i % 2);
    end
    chk("alt_c0", gnt_cnt0, 3);
    chk("alt_c1", gnt_cnt1, 3);

    // Stall while full: outputs hold, readys low; release loads next packet same edge.
    held_data = out_data; held_route = out_route; held_src = out_src;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 11'($urandom), 1'($urandom), 1'b1, 11'($urandom), 1'($urandom), 1'b0);
      #1;
      chk("stall_rdy0", in0_ready, 0);
      chk("stall_rdy1", in1_ready, 0);
      tick();
      chk("stall_ov", out_valid, 1);
      chk("stall_data", out_data, held_data);
      chk("stall_route", out_route, held_route);
      chk("stall_src", out_src, held_src);
    end
    set_in(1'b1, 11'h123, 1'b1, 1'b0, 11'h0, 1'b0, 1'b1);
    #1;
    chk("unstall_rdy0", in0_ready, 1);
    tick();
    chk("unstall_ov", out_valid, 1);
    chk("unstall_data", out_data, 11'h123);
    chk("unstall_src", out_src, 0);

    // Saturation on the narrow-counter instance.
    do_reset();
    set_in(1'b0, 11'h0, 1'b0, 1'b1, 11'h3C3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_small_c1", s_gnt_cnt1, 3);
    chk("sat_wide_c1", gnt_cnt1, 5);
    chk("sat_small_c0", s_gnt_cnt0, 0);

    // Reset while full and stalled discards the packet; requester 0 wins first afterwards.
    do_reset();
    set_in(1'b1, 11'h0F0, 1'b1, 1'b0, 11'h0, 1'b0, 1'b0);
    tick();
    chk("rf_full", out_valid, 1);
    RESET = 1'b1;
    set_in(1'b1, 11'h0F1, 1'b0, 1'b1, 11'h0F2, 1'b1, 1'b0);
    #1;
    chk("rf_rdy0", in0_ready, 0);
    chk("rf_rdy1", in1_ready, 0);
    tick();
    chk("rf_ov", out_valid, 0);
    chk("rf_c0", gnt_cnt0, 0);
    RESET = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rf_first_rdy0", in0_ready, 1);
    chk("rf_first_rdy1", in1_ready, 0);
    tick();
    chk("rf_first_src", out_src, 0);
    chk("rf_first_data", out_data, 11'h0F1);

    // Randomized run against a queue-based scoreboard.
    begin
      int   m_prio, g, c0, c1;
      bit   le;
      pkt_t p;
      do_reset();
      q.delete();
      m_prio = 0; c0 = 0; c1 = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        set_in(1'($urandom_range(0, 2) != 0), 11'($urandom), 1'($urandom),
               1'($urandom_range(0, 2) != 0), 11'($urandom), 1'($urandom),
               1'($urandom_range(0, 3) != 0));
        #1;
        le = (q.size() == 0) || out_ready;
        g = -1;
        if (le) begin
          if (in0_valid && in1_valid) g = m_prio;
          else if (in0_valid) g = 0;
          else if (in1_valid) g = 1;
        end
        chk("rnd_rdy0", in0_ready, (g == 0));
        chk("rnd_rdy1", in1_ready, (g == 1));
        chk("rnd_one_hot", (in0_ready && in1_ready), 0);
        chk("rnd_ov", out_valid, (q.size() != 0));
        if (q.size() != 0) begin
          chk("rnd_data", out_data, q[0].data);
          chk("rnd_route", out_route, q[0].route);
          chk("rnd_src", out_src, q[0].src);
          if (out_ready) void'(q.pop_front());
        end
        if (g == 0) begin
          p.data = in0_data; p.route = in0_route; p.src = 1'b0;
          q.push_back(p); m_prio = 1; if (c0 < 255) c0++;
        end else if (g == 1) begin
          p.data = in1_data; p.route = in1_route; p.src = 1'b1;
          q.push_back(p); m_prio = 0; if (c1 < 255) c1++;
        end
        tick();
        chk("rnd_c0", gnt_cnt0, c0);
        chk("rnd_c1", gnt_cnt1, c1);
        chk("rnd_small_c0", s_gnt_cnt0, (c0 > 3) ? 3 : c0);
        chk("rnd_small_c1", s_gnt_cnt1, (c1 > 3) ? 3 : c1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_merge_arbiter.md
NOC_MERGE_ARBITER -- requirements
Module: noc_merge_arbiter

Interface
REQ-001 Parameter W, default 11, packet data width.
REQ-002 Parameter CW, default 8, grant-counter width.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 in0_data  in  W  requester 0 packet.
REQ-006 in0_route  in  1  requester 0 destination select for downstream split_2.
REQ-007 in0_valid  in  1  requester 0 offers packet.
REQ-008 in0_ready  out  1  requester 0 packet accepted this cycle.
REQ-009 in1_data, in1_route, in1_valid, in1_ready SHALL mirror REQ-005..REQ-008 for requester 1.
REQ-010 out_data  out  W  registered packet to shared datapath.
REQ-011 out_route  out  1  registered route bit, drives split_2 control input.
REQ-012 out_src  out  1  index of requester that supplied the held packet.
REQ-013 out_valid  out  1  output register holds a packet.
REQ-014 out_ready  in  1  downstream consumes packet.
REQ-015 gnt_cnt0, gnt_cnt1  out  CW each  accepted-packet count per requester.

Function
REQ-016 Handshake: transfer on any port occurs in a cycle where valid and ready are both high at the CLK edge.
REQ-017 load_en = !out_valid | out_ready; no input SHALL be accepted when load_en is low.
REQ-018 At most one of in0_ready/in1_ready SHALL be high in any cycle; readys are combinational from valids, load_en and prio.
REQ-019 Arbitration: only one valid -> grant it; both valid -> grant requester indicated by prio register; none valid -> no grant.
REQ-020 After each accepted packet, prio SHALL point to the non-granted requester (round-robin); prio unchanged when nothing is accepted.
REQ-021 Output FSM states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-022 EMPTY + accept -> FULL; EMPTY + no accept -> EMPTY.
REQ-023 FULL + out_ready + accept -> FULL with new packet (back-to-back, no bubble).
REQ-024 FULL + out_ready + no accept -> EMPTY; FULL + !out_ready -> FULL, hold.
REQ-025 Latency: packet accepted at edge N appears with out_valid=1 after edge N; throughput one packet per cycle.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_route, out_src SHALL be stable.
REQ-027 On accept, out_data/out_route SHALL load granted requester's data/route; out_src SHALL load its index.
REQ-028 gnt_cntX increments by 1 on each accept from requester X, saturating at 2^CW-1 (no wrap).
REQ-029 A valid deasserted before being granted produces no transfer and no counter change.
REQ-030 In EMPTY, out_data/out_route/out_src retain last values (don't-care for checker).

Reset
REQ-031 RESET high at a CLK edge: out_valid=0, out_data=0, out_route=0, out_src=0, prio=0, gnt_cnt0=gnt_cnt1=0, FSM=EMPTY.
REQ-032 While RESET is high, in0_ready and in1_ready SHALL be 0.
REQ-033 RESET asserted while FULL SHALL discard the held packet without a downstream transfer.
REQ-034 First cycle after RESET release, block SHALL accept input if any valid is high.

Verification
REQ-035 Only in0_valid with data=0x005, route=1, out_ready=1 -> out_data=0x005, out_route=1, out_src=0 one cycle later; gnt_cnt0=1.
REQ-036 Both valid continuously, out_ready=1 for 6 cycles -> grants alternate 0,1,0,1,0,1; both counters=3; no bubbles.
REQ-037 FULL with out_ready=0 for 5 cycles, inputs changing -> outputs stable, both readys 0; out_ready=1 -> held packet transfers, next packet loads same edge.
REQ-038 CW=2, in1 only, 5 accepts -> gnt_cnt1 saturates at 3.
REQ-039 RESET pulsed while FULL with out_ready=0 -> out_valid=0 next cycle, counters 0, prio=0; both valid after release -> requester 0 granted first.
REQ-040 Randomized valids/out_ready against scoreboard -> every accepted packet delivered once, in order, with correct route/src; readys never both high.
